mul_div_unit: RTL and testbench

Multi-cycle multiply/divide unit for the CPU datapath; owns the HI/LO registers. Consumes operand A from register-file read port 1 and operand B from the ALU B-operand select output, the same value the ALU sees. Runs mult/multu/div/divu with fixed latencies and reports `busy` so hazard control can stall dependent instructions. Also handles mthi/mtlo writes and provides the mfhi/mflo read value.

---
 rtl/mul_div_unit.sv | 127 ++++++++++++
 tb/tb_mul_div_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Results are computed at the start edge,
// held in shadow registers, and committed to HI/LO when the fixed-latency counter expires.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdStart,
  input  logic [2:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic        mdReadHi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdOut
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdOp_t;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, nextState;
  mdOp_t         op;
  logic [CW-1:0] count;
  logic [31:0]   pendHi, pendLo;
  logic          pendValid;
  logic          accept;

  logic [63:0] product;
  logic        negA, negB;
  logic [31:0] magA, magB, divisor, uQuot, uRem, quot, rem;

  assign op     = mdOp_t'(mdOp);
  assign accept = mdStart && (state == IDLE);
  assign busy   = (state == BUSY);
  assign mdOut  = mdReadHi ? hi : lo;

  // Sign-extending to 64 bits lets one unsigned multiply serve both mult and multu.
  always_comb begin
    product = '0;
    if (op == OP_MULT)
      product = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    else
      product = {32'd0, srcA} * {32'd0, srcB};
  end

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    negA    = (op == OP_DIV) && srcA[31];
    negB    = (op == OP_DIV) && srcB[31];
    magA    = negA ? -srcA : srcA;
    magB    = negB ? -srcB : srcB;
    divisor = (magB == '0) ? 32'd1 : magB;
    uQuot   = magA / divisor;
    uRem    = magA % divisor;
    quot    = (negA ^ negB) ? -uQuot : uQuot;
    rem     = negA ? -uRem : uRem;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept && (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU))
              nextState = BUSY;
      BUSY: if (count == CW'(1)) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      count     <= '0;
      pendHi    <= '0;
      pendLo    <= '0;
      pendValid <= 1'b0;
    end else if (accept) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          pendHi    <= product[63:32];
          pendLo    <= product[31:0];
          pendValid <= 1'b1;
          count     <= CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          pendHi    <= rem;
          pendLo    <= quot;
          pendValid <= (srcB != '0);
          count     <= CW'(DIV_CYCLES);
        end
        OP_MTHI: hi <= srcA;
        OP_MTLO: lo <= srcA;
        default: ;
      endcase
    end else if (state == BUSY) begin
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        if (pendValid) begin
          hi <= pendHi;
          lo <= pendLo;
        end
        pendValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset, mdStart, mdReadHi;
  logic [2:0]  mdOp;
  logic [31:0] srcA, srcB;
  logic        busy;
  logic [31:0] hi, lo, mdOut;

  int nChecks = 0;
  int nPass   = 0;
  logic [31:0] refHi = '0;
  logic [31:0] refLo = '0;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .mdStart(mdStart), .mdOp(mdOp),
    .srcA(srcA), .srcB(srcB), .mdReadHi(mdReadHi),
    .busy(busy), .hi(hi), .lo(lo), .mdOut(mdOut)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Architectural effect of one accepted op on HI/LO.
  task automatic modelOp(input int op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      1: begin p = 64'(sa * sb); refHi = p[63:32]; refLo = p[31:0]; end
      2: begin p = {32'd0, a} * {32'd0, b}; refHi = p[63:32]; refLo = p[31:0]; end
      3: if (b != 0) begin
           q = sa / sb; r = sa % sb;
           p = 64'(q); refLo = p[31:0];
           p = 64'(r); refHi = p[31:0];
         end
      4: if (b != 0) begin refLo = a / b; refHi = a % b; end
      5: refHi = a;
      6: refLo = a;
      default: ;
    endcase
  endtask

  // Called just after a rising edge; returns just after a rising edge with busy low.
  task automatic doOp(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
    int n;
    mdStart = 1'b1; mdOp = 3'(op); srcA = a; srcB = b;
    if (op == 5 || op == 6) begin
      #1;
      checkVal({tag, "_preHi"}, hi, refHi);
      checkVal({tag, "_preLo"}, lo, refLo);
      @(posedge clk); #1;
      mdStart = 1'b0;
      modelOp(op, a, b);
      checkVal({tag, "_busy"}, 32'(busy), 32'd0);
    end else if (op >= 1 && op <= 4) begin
      @(posedge clk); #1;
      mdStart = 1'b0; srcA = $urandom; srcB = $urandom;
      checkVal({tag, "_holdHi"}, hi, refHi);
      n = 0;
      while (busy && n < 50) begin
        n++;
        @(posedge clk); #1;
      end
      checkVal({tag, "_cycles"}, 32'(n), (op <= 2) ? MC : DC);
      modelOp(op, a, b);
    end else begin
      @(posedge clk); #1;
      mdStart = 1'b0;
      checkVal({tag, "_busy"}, 32'(busy), 32'd0);
    end
    checkVal({tag, "_hi"}, hi, refHi);
    checkVal({tag, "_lo"}, lo, refLo);
  endtask

  initial begin
    int n;
    int op;
    logic [31:0] a, b;
    reset = 1'b1; mdStart = 1'b0; mdOp = '0; srcA = '0; srcB = '0; mdReadHi = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_hi", hi, 32'd0);
    checkVal("rst_lo", lo, 32'd0);
    checkVal("rst_mdOut", mdOut, 32'd0);

    doOp("mult", 1, 32'hFFFFFFFF, 32'd2);
    checkVal("mult_hiConst", hi, 32'hFFFFFFFF);
    checkVal("mult_loConst", lo, 32'hFFFFFFFE);
    doOp("multu", 2, 32'hFFFFFFFF, 32'd2);
    checkVal("multu_hiConst", hi, 32'h00000001);
    doOp("div", 3, 32'hFFFFFFF9, 32'd2);
    checkVal("div_loConst", lo, 32'hFFFFFFFD);
    checkVal("div_hiConst", hi, 32'hFFFFFFFF);
    doOp("divu", 4, 32'd7, 32'd2);
    doOp("divOvf", 3, 32'h80000000, 32'hFFFFFFFF);
    checkVal("divOvf_loConst", lo, 32'h80000000);
    doOp("mthi", 5, 32'h1234, 32'd0);
    doOp("mtlo", 6, 32'h5678, 32'd0);
    mdReadHi = 1'b1; #1 checkVal("mdOutHi", mdOut, 32'h1234);
    mdReadHi = 1'b0; #1 checkVal("mdOutLo", mdOut, 32'h5678);
    @(posedge clk); #1;
    doOp("divZero", 3, 32'd55, 32'd0);
    checkVal("divZero_hiConst", hi, 32'h1234);
    doOp("divuZero", 4, 32'd55, 32'd0);

    // Start while busy: mthi and divu during the multiply must be ignored.
    mdStart = 1'b1; mdOp = 3'd1; srcA = 32'd3; srcB = 32'd4;
    @(posedge clk); #1;
    mdStart = 1'b0;
    @(posedge clk); #1;
    mdStart = 1'b1; mdOp = 3'd5; srcA = 32'hAAAA;
    @(posedge clk); #1;
    mdOp = 3'd4; srcA = 32'd9; srcB = 32'd3;
    @(posedge clk); #1;
    mdStart = 1'b0;
    n = 3;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    checkVal("startBusy_cycles", 32'(n), MC);
    checkVal("startBusy_hi", hi, 32'd0);
    checkVal("startBusy_lo", lo, 32'd12);
    refHi = 32'd0; refLo = 32'd12;

    // Reset in the 4th busy cycle of a divide aborts it.
    mdStart = 1'b1; mdOp = 3'd4; srcA = 32'd100; srcB = 32'd7;
    @(posedge clk); #1;
    mdStart = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkVal("rstMid_busy", 32'(busy), 32'd0);
    checkVal("rstMid_hi", hi, 32'd0);
    checkVal("rstMid_lo", lo, 32'd0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy || hi != 0 || lo != 0) n++;
      @(posedge clk); #1;
    end
    checkVal("rstMid_quiet", 32'(n), 32'd0);
    refHi = '0; refLo = '0;

    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 7);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 9);
        2:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'h80000000;
      doOp($sformatf("rnd%0d_op%0d", i, op), op, a, b);
      mdReadHi = 1'($urandom_range(0, 1));
      #1 checkVal($sformatf("rnd%0d_mdOut", i), mdOut, mdReadHi ? refHi : refLo);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
